// File: rtl/axibus2rambus.sv
// AXI4 read master that copies a contiguous block of beats from DDR into a local RAM write port.
// Long transfers are split into INCR bursts of at most C_MAX_BURST_LEN beats, one AR outstanding.
module axibus2rambus #(
    parameter int unsigned C_M_AXI_ID_WIDTH   = 1,
    parameter int unsigned C_M_AXI_LEN_WIDTH  = 8,
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 128,
    parameter int unsigned C_RAM_ADDR_WIDTH   = 10,
    parameter int unsigned C_MAX_BURST_LEN    = 16
) (
    input  logic                          I_clk,
    input  logic                          I_rst_n,
    input  logic                          I_ap_start,
    output logic                          O_ap_done,
    output logic                          O_ap_ready,
    output logic                          O_ap_idle,
    output logic                          O_err,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] I_base_addr,
    input  logic [C_RAM_ADDR_WIDTH-1:0]   I_len,
    output logic [C_RAM_ADDR_WIDTH-1:0]   O_waddr,
    output logic                          O_wr,
    output logic [C_M_AXI_DATA_WIDTH-1:0] O_wdata,
    output logic [C_M_AXI_ID_WIDTH-1:0]   O_maxi_arid,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] O_maxi_araddr,
    output logic [C_M_AXI_LEN_WIDTH-1:0]  O_maxi_arlen,
    output logic [2:0]                    O_maxi_arsize,
    output logic [1:0]                    O_maxi_arburst,
    output logic                          O_maxi_arvalid,
    input  logic                          I_maxi_arready,
    input  logic [C_M_AXI_ID_WIDTH-1:0]   I_maxi_rid,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] I_maxi_rdata,
    input  logic [1:0]                    I_maxi_rresp,
    input  logic                          I_maxi_rlast,
    input  logic                          I_maxi_rvalid,
    output logic                          O_maxi_rready
);

    localparam int unsigned Bytes = C_M_AXI_DATA_WIDTH / 8;
    // Wide enough to hold a full 2^LEN-beat burst count.
    localparam int unsigned BW    = C_M_AXI_LEN_WIDTH + 1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StAr   = 2'd1;
    localparam logic [1:0] StRd   = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    logic [1:0]                    state_q, state_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0] addr_ptr_q, addr_ptr_d;
    logic [C_RAM_ADDR_WIDTH-1:0]   remaining_q, remaining_d;
    logic [C_RAM_ADDR_WIDTH-1:0]   wcnt_q, wcnt_d;
    logic [BW-1:0]                 burst_len_q, burst_len_d;
    logic [BW-1:0]                 beat_q, beat_d;
    logic                          arvalid_q, arvalid_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [C_M_AXI_LEN_WIDTH-1:0]  arlen_q, arlen_d;
    logic                          rready_q, rready_d;
    logic                          wr_q, wr_d;
    logic [C_RAM_ADDR_WIDTH-1:0]   waddr_q, waddr_d;
    logic [C_M_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                          done_q, done_d;
    logic                          idle_q, idle_d;
    logic                          err_q, err_d;

    logic [BW-1:0]                 burst_w;
    logic                          beat_w;
    logic                          last_w;

    logic unused_rid;
    assign unused_rid = ^I_maxi_rid;

    function automatic logic [BW-1:0] burst_of(input logic [C_RAM_ADDR_WIDTH-1:0] rem);
        logic [31:0] r;
        r = 32'(rem);
        if (r > C_MAX_BURST_LEN) begin
            return BW'(C_MAX_BURST_LEN);
        end
        return BW'(r);
    endfunction

    assign beat_w = I_maxi_rvalid && rready_q;
    assign last_w = (beat_q == (burst_len_q - BW'(1)));

    always_comb begin
        state_d     = state_q;
        addr_ptr_d  = addr_ptr_q;
        remaining_d = remaining_q;
        wcnt_d      = wcnt_q;
        burst_len_d = burst_len_q;
        beat_d      = beat_q;
        arvalid_d   = arvalid_q;
        araddr_d    = araddr_q;
        arlen_d     = arlen_q;
        rready_d    = rready_q;
        wr_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        done_d      = done_q;
        idle_d      = idle_q;
        err_d       = err_q;
        burst_w     = '0;

        unique case (state_q)
            StIdle: begin
                if (I_ap_start) begin
                    err_d       = 1'b0;
                    idle_d      = 1'b0;
                    wcnt_d      = '0;
                    addr_ptr_d  = I_base_addr;
                    remaining_d = I_len;
                    if (I_len == '0) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        burst_w     = burst_of(I_len);
                        state_d     = StAr;
                        arvalid_d   = 1'b1;
                        araddr_d    = I_base_addr;
                        arlen_d     = C_M_AXI_LEN_WIDTH'(burst_w - BW'(1));
                        burst_len_d = burst_w;
                    end
                end
            end
            StAr: begin
                if (I_maxi_arready) begin
                    arvalid_d   = 1'b0;
                    rready_d    = 1'b1;
                    remaining_d = remaining_q - C_RAM_ADDR_WIDTH'(burst_len_q);
                    addr_ptr_d  = addr_ptr_q
                                + C_M_AXI_ADDR_WIDTH'(32'(burst_len_q) * Bytes);
                    beat_d      = '0;
                    state_d     = StRd;
                end
            end
            StRd: begin
                if (beat_w) begin
                    wr_d    = 1'b1;
                    waddr_d = wcnt_q;
                    wdata_d = I_maxi_rdata;
                    wcnt_d  = wcnt_q + C_RAM_ADDR_WIDTH'(1);
                    beat_d  = beat_q + BW'(1);
                    if (I_maxi_rresp != 2'b00) begin
                        err_d = 1'b1;
                    end
                    // The local beat count decides the burst end; rlast only flags errors.
                    if (I_maxi_rlast != last_w) begin
                        err_d = 1'b1;
                    end
                    if (last_w) begin
                        rready_d = 1'b0;
                        if (remaining_q != '0) begin
                            burst_w     = burst_of(remaining_q);
                            state_d     = StAr;
                            arvalid_d   = 1'b1;
                            araddr_d    = addr_ptr_q;
                            arlen_d     = C_M_AXI_LEN_WIDTH'(burst_w - BW'(1));
                            burst_len_d = burst_w;
                        end else begin
                            state_d = StDone;
                        end
                    end
                end
            end
            StDone: begin
                // First DONE cycle lets the final RAM write land before the done pulse.
                if (done_q) begin
                    done_d  = 1'b0;
                    idle_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            state_q     <= StIdle;
            addr_ptr_q  <= '0;
            remaining_q <= '0;
            wcnt_q      <= '0;
            burst_len_q <= '0;
            beat_q      <= '0;
            arvalid_q   <= 1'b0;
            araddr_q    <= '0;
            arlen_q     <= '0;
            rready_q    <= 1'b0;
            wr_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            done_q      <= 1'b0;
            idle_q      <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_ptr_q  <= addr_ptr_d;
            remaining_q <= remaining_d;
            wcnt_q      <= wcnt_d;
            burst_len_q <= burst_len_d;
            beat_q      <= beat_d;
            arvalid_q   <= arvalid_d;
            araddr_q    <= araddr_d;
            arlen_q     <= arlen_d;
            rready_q    <= rready_d;
            wr_q        <= wr_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            done_q      <= done_d;
            idle_q      <= idle_d;
            err_q       <= err_d;
        end
    end

    assign O_ap_done      = done_q;
    assign O_ap_ready     = done_q;
    assign O_ap_idle      = idle_q;
    assign O_err          = err_q;
    assign O_waddr        = waddr_q;
    assign O_wr           = wr_q;
    assign O_wdata        = wdata_q;
    assign O_maxi_arid    = '0;
    assign O_maxi_araddr  = araddr_q;
    assign O_maxi_arlen   = arlen_q;
    assign O_maxi_arsize  = 3'($clog2(Bytes));
    assign O_maxi_arburst = 2'b01;
    assign O_maxi_arvalid = arvalid_q;
    assign O_maxi_rready  = rready_q;

endmodule

// File: tb/tb_axibus2rambus.sv
// Table-driven bench for axibus2rambus: an AXI read slave model feeds each transfer and
// every RAM write, AR request and handshake pulse is compared with hand-computed values.
module tb_axibus2rambus;

    logic         I_clk;
    logic         I_rst_n;
    logic         I_ap_start;
    logic         O_ap_done;
    logic         O_ap_ready;
    logic         O_ap_idle;
    logic         O_err;
    logic [31:0]  I_base_addr;
    logic [9:0]   I_len;
    logic [9:0]   O_waddr;
    logic         O_wr;
    logic [127:0] O_wdata;
    logic [0:0]   O_maxi_arid;
    logic [31:0]  O_maxi_araddr;
    logic [7:0]   O_maxi_arlen;
    logic [2:0]   O_maxi_arsize;
    logic [1:0]   O_maxi_arburst;
    logic         O_maxi_arvalid;
    logic         I_maxi_arready;
    logic [0:0]   I_maxi_rid;
    logic [127:0] I_maxi_rdata;
    logic [1:0]   I_maxi_rresp;
    logic         I_maxi_rlast;
    logic         I_maxi_rvalid;
    logic         O_maxi_rready;

    axibus2rambus dut (
        .I_clk          (I_clk),
        .I_rst_n        (I_rst_n),
        .I_ap_start     (I_ap_start),
        .O_ap_done      (O_ap_done),
        .O_ap_ready     (O_ap_ready),
        .O_ap_idle      (O_ap_idle),
        .O_err          (O_err),
        .I_base_addr    (I_base_addr),
        .I_len          (I_len),
        .O_waddr        (O_waddr),
        .O_wr           (O_wr),
        .O_wdata        (O_wdata),
        .O_maxi_arid    (O_maxi_arid),
        .O_maxi_araddr  (O_maxi_araddr),
        .O_maxi_arlen   (O_maxi_arlen),
        .O_maxi_arsize  (O_maxi_arsize),
        .O_maxi_arburst (O_maxi_arburst),
        .O_maxi_arvalid (O_maxi_arvalid),
        .I_maxi_arready (I_maxi_arready),
        .I_maxi_rid     (I_maxi_rid),
        .I_maxi_rdata   (I_maxi_rdata),
        .I_maxi_rresp   (I_maxi_rresp),
        .I_maxi_rlast   (I_maxi_rlast),
        .I_maxi_rvalid  (I_maxi_rvalid),
        .O_maxi_rready  (O_maxi_rready)
    );

    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    typedef struct {
        logic [31:0]      base;
        logic [9:0]       len;
        int               ar_delay;
        bit               toggle;
        int               err_beat;
        bit               rlast_bad;
        int               abort_at;
        int               exp_nb;
        logic [2:0][31:0] exp_addr;
        logic [2:0][7:0]  exp_arlen;
        bit               exp_err;
        int               err_from;
    } vec_t;

    vec_t tbl [7];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Beat payload is derived from its byte address so misplaced beats are visible.
    function automatic logic [127:0] mk(input logic [31:0] a);
        return {a ^ 32'hD0D0_0000, a, ~a, a + 32'h0000_0011};
    endfunction

    function automatic vec_t mkv(input logic [31:0] base, input logic [9:0] len, input int dly,
                                 input bit tog, input int errb, input bit rlb, input int abrt,
                                 input int nb, input logic [31:0] a0, input logic [31:0] a1,
                                 input logic [31:0] a2, input logic [7:0] l0,
                                 input logic [7:0] l1, input logic [7:0] l2, input bit e,
                                 input int efrom);
        vec_t v;
        v.base      = base;
        v.len       = len;
        v.ar_delay  = dly;
        v.toggle    = tog;
        v.err_beat  = errb;
        v.rlast_bad = rlb;
        v.abort_at  = abrt;
        v.exp_nb    = nb;
        v.exp_addr  = {a2, a1, a0};
        v.exp_arlen = {l2, l1, l0};
        v.exp_err   = e;
        v.err_from  = efrom;
        return v;
    endfunction

    // Starts at a falling edge, plays the AXI slave and watches the RAM port until done.
    task automatic run_xfer(input vec_t v);
        logic [31:0] rec_addr [8];
        logic [7:0]  rec_len  [8];
        logic [31:0] held_addr;
        logic [7:0]  held_len;
        logic [31:0] cur_addr;
        int nar = 0, nwr = 0, ndone = 0, cyc = 0, done_cyc = -1, last_wr = -1;
        int ar_wait = 0, beats_left = 0, gidx = 0;
        bit waiting = 0, unstable = 0, overlap = 0, tog = 0, finished = 0, const_bad = 0;
        held_addr   = '0;
        held_len    = '0;
        cur_addr    = '0;
        I_base_addr = v.base;
        I_len       = v.len;
        I_ap_start  = 1'b1;
        @(negedge I_clk);
        I_ap_start = 1'b0;
        chk("start_idle_low", O_ap_idle, 0);
        chk("start_err_clear", O_err, 0);
        chk("start_arvalid", O_maxi_arvalid, v.len != 0);
        while (!finished && cyc < 400) begin
            cyc++;
            if (O_wr) begin
                chk("waddr", O_waddr, nwr);
                chk("wdata", O_wdata, mk(v.base + 32'(nwr) * 16));
                chk("err_on_write", O_err, (v.err_from >= 0) && (nwr >= v.err_from));
                nwr++;
                last_wr = cyc;
            end
            if (O_ap_done) begin
                ndone++;
                done_cyc = cyc;
                chk("ready_eq_done", O_ap_ready, 1);
                chk("idle_low_at_done", O_ap_idle, 0);
            end else if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                chk("idle_after_done", O_ap_idle, 1);
                finished = 1;
            end
            if (v.abort_at > 0 && nwr >= v.abort_at) return;
            if (beats_left > 0) begin
                if (v.toggle && tog) begin
                    I_maxi_rvalid = 1'b0;
                end else begin
                    I_maxi_rvalid = 1'b1;
                    I_maxi_rdata  = mk(cur_addr);
                    I_maxi_rresp  = (gidx == v.err_beat) ? 2'b10 : 2'b00;
                    I_maxi_rlast  = (beats_left == 1) && !v.rlast_bad;
                end
                if (v.toggle) tog = !tog;
                if (I_maxi_rvalid && O_maxi_rready) begin
                    beats_left--;
                    gidx++;
                    cur_addr = cur_addr + 32'd16;
                end
            end else begin
                I_maxi_rvalid = 1'b0;
                I_maxi_rlast  = 1'b0;
            end
            I_maxi_arready = 1'b0;
            if (O_maxi_arvalid) begin
                if (beats_left > 0) overlap = 1;
                if (waiting && (O_maxi_araddr !== held_addr || O_maxi_arlen !== held_len))
                    unstable = 1;
                if (O_maxi_arsize !== 3'd4 || O_maxi_arburst !== 2'b01 || O_maxi_arid !== 1'b0)
                    const_bad = 1;
                if (ar_wait == v.ar_delay) begin
                    I_maxi_arready = 1'b1;
                    if (nar < 8) begin
                        rec_addr[nar] = O_maxi_araddr;
                        rec_len[nar]  = O_maxi_arlen;
                    end
                    nar++;
                    beats_left = int'(O_maxi_arlen) + 1;
                    cur_addr   = O_maxi_araddr;
                    ar_wait    = 0;
                    waiting    = 0;
                end else begin
                    if (!waiting) begin
                        held_addr = O_maxi_araddr;
                        held_len  = O_maxi_arlen;
                    end
                    waiting = 1;
                    ar_wait++;
                end
            end
            @(negedge I_clk);
        end
        chk("finished_in_budget", finished, 1);
        chk("ar_count", nar, v.exp_nb);
        for (int i = 0; i < v.exp_nb && i < nar && i < 3; i++) begin
            chk("araddr", rec_addr[i], v.exp_addr[i]);
            chk("arlen", rec_len[i], v.exp_arlen[i]);
        end
        chk("wr_count", nwr, v.len);
        chk("done_count", ndone, 1);
        chk("done_latency", done_cyc, (v.len == 0) ? 1 : last_wr + 1);
        chk("err_final", O_err, v.exp_err);
        chk("ar_stable", unstable, 0);
        chk("ar_single_outstanding", overlap, 0);
        chk("ar_constants", const_bad, 0);
    endtask

    initial begin
        tbl[0] = mkv(32'h1000, 10'd5,  0, 0, -1, 0, 0, 1, 32'h1000, 32'h0, 32'h0,
                     8'd4, 8'd0, 8'd0, 0, -1);
        tbl[1] = mkv(32'h0000, 10'd40, 0, 0, -1, 0, 0, 3, 32'h000, 32'h100, 32'h200,
                     8'd15, 8'd15, 8'd7, 0, -1);
        tbl[2] = mkv(32'h2000, 10'd6,  3, 1, -1, 0, 0, 1, 32'h2000, 32'h0, 32'h0,
                     8'd5, 8'd0, 8'd0, 0, -1);
        tbl[3] = mkv(32'h3000, 10'd0,  0, 0, -1, 0, 0, 0, 32'h0, 32'h0, 32'h0,
                     8'd0, 8'd0, 8'd0, 0, -1);
        tbl[4] = mkv(32'h4000, 10'd8,  0, 0, 2, 0, 0, 1, 32'h4000, 32'h0, 32'h0,
                     8'd7, 8'd0, 8'd0, 1, 2);
        tbl[5] = mkv(32'h5000, 10'd3,  0, 0, -1, 1, 0, 1, 32'h5000, 32'h0, 32'h0,
                     8'd2, 8'd0, 8'd0, 1, 2);
        tbl[6] = mkv(32'h6000, 10'd17, 1, 0, -1, 0, 0, 2, 32'h6000, 32'h6100, 32'h0,
                     8'd15, 8'd0, 8'd0, 0, -1);

        I_rst_n        = 1'b0;
        I_ap_start     = 1'b0;
        I_base_addr    = '0;
        I_len          = '0;
        I_maxi_arready = 1'b0;
        I_maxi_rid     = '0;
        I_maxi_rdata   = '0;
        I_maxi_rresp   = 2'b00;
        I_maxi_rlast   = 1'b0;
        I_maxi_rvalid  = 1'b0;
        repeat (3) @(negedge I_clk);
        chk("rst_idle", O_ap_idle, 1);
        chk("rst_done", O_ap_done, 0);
        chk("rst_ready", O_ap_ready, 0);
        chk("rst_err", O_err, 0);
        chk("rst_arvalid", O_maxi_arvalid, 0);
        chk("rst_rready", O_maxi_rready, 0);
        chk("rst_wr", O_wr, 0);
        chk("rst_waddr", O_waddr, 0);
        chk("rst_wdata", O_wdata, 0);
        chk("rst_araddr", O_maxi_araddr, 0);
        chk("rst_arlen", O_maxi_arlen, 0);
        I_rst_n = 1'b1;
        @(negedge I_clk);

        for (int t = 0; t < 7; t++) begin
            run_xfer(tbl[t]);
        end

        // Reset in the middle of the first burst of a 32-beat transfer.
        run_xfer(mkv(32'h8000, 10'd32, 0, 0, -1, 0, 5, 0, 32'h0, 32'h0, 32'h0,
                     8'd0, 8'd0, 8'd0, 0, -1));
        I_rst_n        = 1'b0;
        I_maxi_rvalid  = 1'b0;
        I_maxi_arready = 1'b0;
        @(negedge I_clk);
        chk("midrst_idle", O_ap_idle, 1);
        chk("midrst_arvalid", O_maxi_arvalid, 0);
        chk("midrst_rready", O_maxi_rready, 0);
        chk("midrst_wr", O_wr, 0);
        chk("midrst_done", O_ap_done, 0);
        I_rst_n = 1'b1;
        run_xfer(mkv(32'h9000, 10'd4, 0, 0, -1, 0, 0, 1, 32'h9000, 32'h0, 32'h0,
                     8'd3, 8'd0, 8'd0, 0, -1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
